// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU replacement state for an N-way set-associative cache.
// Optional per-way valid tracking with invalidate is enabled by defining PLRU_VALID_EN.
module plru_array #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16,
    parameter int WAY_W    = $clog2(NUM_WAYS),
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk0,
    input  logic             rst0_n,
    input  logic             csb0,
    input  logic             web0,
    input  logic [SET_W-1:0] addr0,
    input  logic [WAY_W-1:0] din0,
`ifdef PLRU_VALID_EN
    input  logic             inv0,
`endif
    output logic [WAY_W-1:0] dout0
);

    localparam int Nodes = NUM_WAYS - 1;

    logic [NUM_SETS-1:0][Nodes-1:0] tree_q, tree_d;
    logic [WAY_W-1:0]               dout_q, dout_d;
    logic [Nodes-1:0]               row;
    logic [Nodes-1:0]               upd;
    logic [WAY_W-1:0]               tree_vic;
    logic [WAY_W-1:0]               vic;
    logic                           bit_sel;
    logic                           do_wr;
    logic                           do_rd;

`ifdef PLRU_VALID_EN
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
    logic [NUM_WAYS-1:0]               vrow;
`endif

    assign do_wr = !csb0 && !web0;
    assign do_rd = !csb0 && web0;

    always_comb begin
        row = tree_q[addr0];

        // Nodes on the path to din0 point away from the branch taken toward it.
        upd = row;
        for (int l = 0; l < WAY_W; l++) begin
            for (int j = 0; j < (1 << l); j++) begin
                if (j == (int'(din0) >> (WAY_W - l))) begin
                    upd[(1 << l) - 1 + j] = ((int'(din0) >> (WAY_W - 1 - l)) & 1) == 0;
                end
            end
        end

        // Walk from the root; the accumulated prefix selects the node at each level.
        tree_vic = '0;
        bit_sel  = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            bit_sel = 1'b0;
            for (int j = 0; j < (1 << l); j++) begin
                if (j == int'(tree_vic)) begin
                    bit_sel = row[(1 << l) - 1 + j];
                end
            end
            tree_vic = (tree_vic << 1) | WAY_W'(bit_sel);
        end
    end

`ifdef PLRU_VALID_EN
    always_comb begin
        tree_d  = tree_q;
        valid_d = valid_q;
        vrow    = valid_q[addr0];
        vic     = tree_vic;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!vrow[w]) begin
                vic = WAY_W'(w);
            end
        end
        if (do_wr) begin
            if (inv0) begin
                valid_d[addr0] = '0;
            end else begin
                valid_d[addr0][din0] = 1'b1;
                tree_d[addr0]        = upd;
            end
        end
    end
`else
    always_comb begin
        tree_d = tree_q;
        vic    = tree_vic;
        if (do_wr) begin
            tree_d[addr0] = upd;
        end
    end
`endif

    always_comb begin
        dout_d = dout_q;
        if (do_rd) begin
            dout_d = vic;
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            tree_q <= '0;
            dout_q <= '0;
        end else begin
            tree_q <= tree_d;
            dout_q <= dout_d;
        end
    end

`ifdef PLRU_VALID_EN
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end
`endif

    assign dout0 = dout_q;

endmodule

// File: tb/tb_plru_array.sv
// Directed bench for plru_array: a 4-way/16-set instance and a 2-way instance.
module tb_plru_array;

    logic       clk;
    logic       rst_n;
    logic       csb, web;
    logic [3:0] addr;
    logic [1:0] din;
    logic [1:0] dout;
    logic       csb2, web2;
    logic [3:0] addr2;
    logic [0:0] din2;
    logic [0:0] dout2;
`ifdef PLRU_VALID_EN
    logic       inv, inv2;
`endif

    int total = 0;
    int bad   = 0;

    plru_array #(.NUM_WAYS(4), .NUM_SETS(16)) dut (
        .clk0   (clk),
        .rst0_n (rst_n),
        .csb0   (csb),
        .web0   (web),
        .addr0  (addr),
        .din0   (din),
`ifdef PLRU_VALID_EN
        .inv0   (inv),
`endif
        .dout0  (dout)
    );

    plru_array #(.NUM_WAYS(2), .NUM_SETS(16)) dut2 (
        .clk0   (clk),
        .rst0_n (rst_n),
        .csb0   (csb2),
        .web0   (web2),
        .addr0  (addr2),
        .din0   (din2),
`ifdef PLRU_VALID_EN
        .inv0   (inv2),
`endif
        .dout0  (dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        csb = 1'b1;
        web = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] s, input logic [1:0] w);
        csb  = 1'b0;
        web  = 1'b0;
        addr = s;
        din  = w;
`ifdef PLRU_VALID_EN
        inv  = 1'b0;
`endif
        @(posedge clk);
        #1;
        csb = 1'b1;
    endtask

    task automatic rd(input logic [3:0] s);
        csb  = 1'b0;
        web  = 1'b1;
        addr = s;
        @(posedge clk);
        #1;
        csb = 1'b1;
    endtask

    task automatic wr2(input logic w);
        csb2  = 1'b0;
        web2  = 1'b0;
        addr2 = 4'd2;
        din2  = w;
        @(posedge clk);
        #1;
        csb2 = 1'b1;
    endtask

    task automatic rd2();
        csb2  = 1'b0;
        web2  = 1'b1;
        addr2 = 4'd2;
        @(posedge clk);
        #1;
        csb2 = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        csb   = 1'b1;
        web   = 1'b1;
        addr  = '0;
        din   = '0;
        csb2  = 1'b1;
        web2  = 1'b1;
        addr2 = '0;
        din2  = '0;
`ifdef PLRU_VALID_EN
        inv   = 1'b0;
        inv2  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_dout2", 4'(dout2), 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        rd(4'd5);
        chk("rd_set5_after_reset", dout, 0);

`ifndef PLRU_VALID_EN
        wr(4'd3, 2'd0);
        rd(4'd3);
        chk("set3_w0", dout, 2);
        wr(4'd3, 2'd2);
        rd(4'd3);
        chk("set3_w2", dout, 1);

        wr(4'd7, 2'd0);
        wr(4'd7, 2'd1);
        wr(4'd7, 2'd2);
        wr(4'd7, 2'd3);
        rd(4'd7);
        chk("set7_fill", dout, 0);
        rd(4'd8);
        chk("set8_isolated", dout, 0);
        rd(4'd3);
        chk("set3_isolated", dout, 1);

        idle(3);
        chk("hold_idle", dout, 1);
        wr(4'd3, 2'd1);
        chk("hold_write", dout, 1);
        rd(4'd3);
        chk("set3_w1_b2b", dout, 3);
        wr(4'd3, 2'd3);
        rd(4'd3);
        chk("set3_w3_b2b", dout, 0);

        wr(4'd9, 2'd1);
        rd(4'd9);
        chk("set9_w1", dout, 2);
`else
        wr(4'd4, 2'd0);
        wr(4'd4, 2'd1);
        rd(4'd4);
        chk("v_set4_w01", dout, 2);
        wr(4'd4, 2'd2);
        rd(4'd4);
        chk("v_set4_w012", dout, 3);

        wr(4'd6, 2'd0);
        wr(4'd6, 2'd1);
        wr(4'd6, 2'd2);
        wr(4'd6, 2'd3);
        rd(4'd6);
        chk("v_set6_fill_tree", dout, 0);
        idle(2);
        chk("v_hold_idle", dout, 0);

        csb  = 1'b0;
        web  = 1'b0;
        addr = 4'd6;
        din  = 2'd3;
        inv  = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
        csb = 1'b1;
        rd(4'd6);
        chk("v_set6_inv", dout, 0);
        wr(4'd6, 2'd0);
        rd(4'd6);
        chk("v_set6_inv_w0", dout, 1);
        rd(4'd4);
        chk("v_set4_isolated", dout, 3);

        wr(4'd9, 2'd0);
        wr(4'd9, 2'd1);
        rd(4'd9);
        chk("set9_w01", dout, 2);
`endif

        // Asynchronous reset between edges clears dout and all history.
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_dout", dout, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(4'd9);
        chk("set9_after_reset", dout, 0);
        rd(4'd3);
        chk("set3_after_reset", dout, 0);

        wr2(1'b0);
        rd2();
        chk("w2_way0", 4'(dout2), 1);
        wr2(1'b1);
        rd2();
        chk("w2_way1", 4'(dout2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plru_array.md
Name: plru_array

Overview:
- Per-set tree pseudo-LRU replacement state for an N-way set-associative cache; the generalised successor of the single-set 2-way PLRU bit.
- Sits beside the tag/data arrays and uses the same SRAM-style port (chip select, write enable, address).
- On a hit or fill, the cache controller writes the accessed way. On a miss, it reads the victim way for a set.
- All state is held in flops, so no SRAM macro is needed.

Parameters:
- NUM_WAYS, 4, associativity; power of two, 2..16.
- NUM_SETS, 16, number of sets; power of two, 2..256.
- WAY_W, $clog2(NUM_WAYS), width of the way index (derived; do not override).
- SET_W, $clog2(NUM_SETS), width of the set index (derived; do not override).

Ports:
- clk0  in  1  clock; all state updates on the rising edge.
- rst0_n  in  1  asynchronous, active-low reset.
- csb0  in  1  chip select, active low; the port is idle when high.
- web0  in  1  write enable, active low; 0 = update (access), 1 = read victim.
- addr0  in  SET_W  set index.
- din0  in  WAY_W  way accessed (used on writes only).
- dout0  out  WAY_W  registered victim way of the last read set.

Behaviour:
- Storage: NUM_SETS entries, each NUM_WAYS-1 tree bits, heap-indexed.
  - Node 0 is the root; node i has children 2i+1 (left, lower ways) and 2i+2 (right).
  - Node bit b points toward the LRU side: 0 = left subtree, 1 = right subtree.
- Reset:
  - Asserting rst0_n low immediately clears every tree bit and dout0 to 0, regardless of clk0.
  - Deassertion is synchronised externally; no operation is accepted on the deassertion edge's cycle.
  - Reset asserted mid-sequence discards all history.
- Idle (csb0=1): no state change; dout0 holds its value.
- Read (csb0=0, web0=1):
  - Walk set addr0 from the root, following each node bit, to reach a leaf way.
  - Register that way into dout0 at the clock edge; it is valid 1 cycle after the request.
  - dout0 holds until the next read. Tree bits are unchanged.
- Write (csb0=0, web0=0):
  - For every node on the path from the root to way din0, set the bit to point away from din0's branch: left branch -> 1, right branch -> 0.
  - Nodes off the path are unchanged. The update is visible to a read on the next cycle.
  - dout0 is unchanged.
- Set independence: a write to one set never alters another set's bits.
- NUM_WAYS=2: single bit per set. Access way 0 -> bit 1; access way 1 -> bit 0; victim = bit.
- Back-to-back operations on the same set, in any mix, are all honoured with no stall.
- The port is single-ported: simultaneous read and write is impossible by encoding, and there is no busy/ready signal.
- Out-of-range din0 cannot occur because widths are exact powers of two.

Optional Feature:
Macro: PLRU_VALID_EN
- Defined:
  - Adds input inv0 (1 bit) and a per-set valid vector of NUM_WAYS bits, cleared by reset.
  - A write with inv0=1 clears all valid bits of set addr0 and leaves the tree bits unchanged.
  - A write with inv0=0 sets valid[din0] as well as updating the tree.
  - A read returns the lowest-indexed invalid way if any way is invalid; otherwise it returns the tree victim.
- Undefined: no inv0 port, no valid storage; the victim is always the tree result.

Test Plan (NUM_WAYS=4, NUM_SETS=16 unless noted):
- Reset, then read set 5 -> dout0=0 one cycle later. Assert rst0_n mid-run between clock edges -> dout0 drops to 0 immediately.
- Set 3: write way 0, then read -> dout0=2. Write way 2, then read -> dout0=1.
- Set 7: write ways 0,1,2,3 in consecutive cycles, then read -> dout0=0. Read set 8 -> dout0=0 (set isolation).
- Idle cycles (csb0=1) and writes between reads -> dout0 holds its last read value. Read immediately after a write to the same set reflects the write.
- NUM_WAYS=2 build: reset, write way 0, read -> dout0=1; write way 1, read -> dout0=0.
- PLRU_VALID_EN:
  - After reset, read -> 0. Write way 0 and write way 1, read -> 2.
  - Fill all 4 ways in order 0,1,2,3, read -> 0 (tree).
  - Write inv0=1 to the set, read -> 0. Write way 0, read -> 1.
